// File: rtl/thirteen_bit_down_timer.sv
// Loadable down-counter: Load starts a countdown of LoadValue enabled cycles, Done pulses one cycle at expiry.
// Priority Load > Abort > Enable; optional auto-reload turns it into a periodic (N+1)-cycle tick.
module thirteen_bit_down_timer #(
    parameter int WIDTH       = 13,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;

    state_t           w_next_state;
    logic [WIDTH-1:0] w_next_count;
    logic [WIDTH-1:0] w_next_reload;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_count  <= ZERO;
            r_reload <= ZERO;
        end else begin
            r_state  <= w_next_state;
            r_count  <= w_next_count;
            r_reload <= w_next_reload;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_count  = r_count;
        w_next_reload = r_reload;
        if (i_load) begin
            w_next_reload = i_load_value;
            w_next_count  = i_load_value;
            // A zero load expires immediately without any RUN cycle.
            w_next_state  = (i_load_value != ZERO) ? S_RUN : S_EXPIRED;
        end else if (i_abort) begin
            w_next_state = S_IDLE;
            w_next_count = ZERO;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (i_enable) begin
                        if (r_count <= ONE) begin
                            w_next_count = ZERO;
                            w_next_state = S_EXPIRED;
                        end else begin
                            w_next_count = r_count - ONE;
                        end
                    end
                end
                S_EXPIRED: begin
                    // Reload ignores Enable; a zero reload value falls back to IDLE to avoid a stuck Done.
                    if (AUTO_RELOAD && (r_reload != ZERO)) begin
                        w_next_count = r_reload;
                        w_next_state = S_RUN;
                    end else begin
                        w_next_count = ZERO;
                        w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_busy  = (r_state == S_RUN);
        o_done  = (r_state == S_EXPIRED);
        o_count = r_count;
    end

endmodule
